// File: rtl/bandai_mapper_gen2_pkg.sv
// Shared constants and types for the gen2 cartridge mapper: unlock keys,
// register map and unlock FSM states.
package bandai_mapper_gen2_pkg;

   localparam logic [7:0] KEY0       = 8'h5A;
   localparam logic [7:0] KEY1       = 8'hA5;
   localparam logic [7:0] RELOCK_CMD = 8'hA5;

   localparam logic [7:0] REG_LAO    = 8'hC0;
   localparam logic [7:0] REG_RAM    = 8'hC1;
   localparam logic [7:0] REG_ROM0   = 8'hC2;
   localparam logic [7:0] REG_IO_OE  = 8'hCC;
   localparam logic [7:0] REG_IO_O   = 8'hCD;
   localparam logic [7:0] REG_RELOCK = 8'hCF;

   typedef enum logic [1:0] {
      ST_LOCK_A   = 2'd0,
      ST_LOCK_B   = 2'd1,
      ST_UNLOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/bandai_mapper_gen2_sync2.sv
// Two-flop synchroniser with a configurable width and reset value.
module bandai_sync2 #(
   parameter int unsigned     W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
)(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/bandai_mapper_gen2.sv
// Gen2 cartridge mapper: unlock handshake, boot bit-stream, bank/GPIO
// registers and ROM/RAM chip-select decode for the console cart bus.
module bandai_mapper_gen2
   import bandai_mapper_gen2_pkg::*;
#(
   parameter int unsigned          ROM_BANKS    = 2,
   parameter int unsigned          RADDR_W      = 7,
   parameter int unsigned          GPIO_W       = 4,
   parameter int unsigned          BOOT_LEN     = 18,
   parameter logic [BOOT_LEN-1:0]  BOOT_PATTERN = 18'h05140,
   parameter logic [7:0]           UNLOCK_KEY0  = KEY0,
   parameter logic [7:0]           UNLOCK_KEY1  = KEY1
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cen,
   input  logic               i_ssn,
   input  logic               i_oen,
   input  logic               i_wen,
   input  logic [7:0]         i_addr,
   input  logic [7:0]         i_dq,
   output logic [7:0]         o_dq,
   output logic               o_dq_oe,
   output logic               o_so,
   input  logic [GPIO_W-1:0]  i_io,
   output logic [GPIO_W-1:0]  o_io,
   output logic [GPIO_W-1:0]  o_io_oe,
   output logic               o_romcen,
   output logic               o_ramcen,
   output logic [RADDR_W-1:0] o_raddr
);

   localparam int unsigned LAO_W = RADDR_W - 4;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_unlocked;
   logic                w_key_load;

   logic [1:0]          w_strb_s;
   logic                w_wen_s;
   logic                w_rw_s;
   logic                r_rw_d;
   logic                w_rw_rise;
   logic [GPIO_W-1:0]   w_io_s;

   logic [7:0]          r_cap_addr;
   logic [7:0]          r_cap_data;
   logic                r_pend;
   logic                w_capture;
   logic                w_commit;
   logic                w_relock;
   logic [7:0]          w_wr_off;
   logic                w_wr_rom;

   logic [BOOT_LEN-1:0] r_sh;
   logic [LAO_W-1:0]    r_lao;
   logic [RADDR_W-1:0]  r_ram;
   logic [RADDR_W-1:0]  r_rom [ROM_BANKS];
   logic [RADDR_W-1:0]  w_rom_pad [4];
   logic [GPIO_W-1:0]   r_io_oe;
   logic [GPIO_W-1:0]   r_io_o;
   logic [GPIO_W-1:0]   w_io_rd;

   logic [7:0]          w_rd_off;
   logic                w_mapped;
   logic [7:0]          w_rd_data;
   logic                w_dq_oe;

   logic [3:0]          w_n;
   logic [1:0]          w_rom_idx;
   logic                w_sel;
   logic                w_rom_sel;
   logic                w_ram_sel;
   logic [RADDR_W-1:0]  w_raddr;

   // Strobes idle high; bit 1 is WEn, bit 0 is the combined rw strobe.
   bandai_sync2 #(.W(2), .RST_VAL(2'b11)) u_sync_strb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   ({i_wen, i_oen & i_wen}),
      .o_q   (w_strb_s)
   );

   bandai_sync2 #(.W(GPIO_W), .RST_VAL({GPIO_W{1'b0}})) u_sync_io (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_io),
      .o_q   (w_io_s)
   );

   assign w_wen_s   = w_strb_s[1];
   assign w_rw_s    = w_strb_s[0];
   assign w_rw_rise = w_rw_s & ~r_rw_d;
   assign w_capture = ~w_wen_s & ~(i_ssn & i_cen);
   assign w_commit  = w_rw_rise & r_pend & w_unlocked;
   assign w_relock  = w_commit & (r_cap_addr == REG_RELOCK) & (r_cap_data == RELOCK_CMD);
   assign w_wr_off  = r_cap_addr - REG_ROM0;
   assign w_wr_rom  = (r_cap_addr >= REG_ROM0) && (w_wr_off < 8'(ROM_BANKS));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_LOCK_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOCK_A: begin
            if (i_addr == UNLOCK_KEY0) w_state_nxt = ST_LOCK_B;
            else                       w_state_nxt = ST_LOCK_A;
         end
         ST_LOCK_B: begin
            if (i_addr == UNLOCK_KEY1)      w_state_nxt = ST_UNLOCKED;
            else if (i_addr == UNLOCK_KEY0) w_state_nxt = ST_LOCK_B;
            else                            w_state_nxt = ST_LOCK_A;
         end
         ST_UNLOCKED: begin
            if (w_relock) w_state_nxt = ST_LOCK_A;
            else          w_state_nxt = ST_UNLOCKED;
         end
         default: w_state_nxt = ST_LOCK_A;
      endcase
   end

   always_comb begin
      w_unlocked = (r_state == ST_UNLOCKED);
      w_key_load = (r_state == ST_LOCK_B) && (i_addr == UNLOCK_KEY1);
   end

   // Boot stream shifts every cycle; ones refill so SO idles high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh <= '1;
      end else if (w_key_load) begin
         r_sh <= BOOT_PATTERN;
      end else begin
         r_sh <= {1'b1, r_sh[BOOT_LEN-1:1]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rw_d     <= 1'b1;
         r_pend     <= 1'b0;
         r_cap_addr <= 8'h00;
         r_cap_data <= 8'h00;
      end else begin
         r_rw_d <= w_rw_s;
         if (w_capture) begin
            r_cap_addr <= i_addr;
            r_cap_data <= i_dq;
            r_pend     <= 1'b1;
         end else if (w_rw_rise) begin
            r_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lao   <= '1;
         r_ram   <= '1;
         r_io_oe <= '0;
         r_io_o  <= '0;
         for (int i = 0; i < ROM_BANKS; i++) r_rom[i] <= '1;
      end else if (w_commit) begin
         case (r_cap_addr)
            REG_LAO:   r_lao   <= r_cap_data[LAO_W-1:0];
            REG_RAM:   r_ram   <= r_cap_data[RADDR_W-1:0];
            REG_IO_OE: r_io_oe <= r_cap_data[GPIO_W-1:0];
            REG_IO_O:  r_io_o  <= r_cap_data[GPIO_W-1:0];
            default: begin
            end
         endcase
         for (int i = 0; i < ROM_BANKS; i++) begin
            if (w_wr_rom && (w_wr_off == 8'(i))) r_rom[i] <= r_cap_data[RADDR_W-1:0];
         end
      end
   end

   // Pad the ROM bank file to four entries so a 2-bit index is always in range.
   for (genvar g = 0; g < 4; g++) begin : g_rom_pad
      if (g < ROM_BANKS) begin : g_used
         assign w_rom_pad[g] = r_rom[g];
      end else begin : g_unused
         assign w_rom_pad[g] = '0;
      end
   end

   assign w_io_rd  = (r_io_oe & r_io_o) | (~r_io_oe & w_io_s);
   assign w_rd_off = i_addr - REG_ROM0;

   always_comb begin
      w_mapped  = 1'b0;
      w_rd_data = 8'h00;
      case (i_addr)
         REG_LAO:   begin w_mapped = 1'b1; w_rd_data = 8'(r_lao);   end
         REG_RAM:   begin w_mapped = 1'b1; w_rd_data = 8'(r_ram);   end
         REG_IO_OE: begin w_mapped = 1'b1; w_rd_data = 8'(r_io_oe); end
         REG_IO_O:  begin w_mapped = 1'b1; w_rd_data = 8'(w_io_rd); end
         default: begin
            if ((i_addr >= REG_ROM0) && (w_rd_off < 8'(ROM_BANKS))) begin
               w_mapped  = 1'b1;
               w_rd_data = 8'(w_rom_pad[w_rd_off[1:0]]);
            end else begin
               w_mapped  = 1'b0;
               w_rd_data = 8'h00;
            end
         end
      endcase
   end

   assign w_dq_oe   = w_unlocked & ~(i_ssn & i_cen) & ~i_oen & i_wen & w_mapped;

   assign w_n       = i_addr[7:4];
   assign w_rom_idx = w_n[1:0] - 2'd2;
   assign w_sel     = w_unlocked & i_ssn & ~i_cen;
   assign w_ram_sel = w_sel & (w_n == 4'd1);
   assign w_rom_sel = w_sel & (w_n >= 4'd2);

   // Windows past the ROM bank registers map linearly through LAO.
   always_comb begin
      w_raddr = '0;
      if (w_rom_sel) begin
         if (w_n < 4'(ROM_BANKS + 2)) w_raddr = w_rom_pad[w_rom_idx];
         else                         w_raddr = {r_lao, w_n};
      end else if (w_ram_sel) begin
         w_raddr = r_ram;
      end else begin
         w_raddr = '0;
      end
   end

   assign o_dq     = w_dq_oe ? w_rd_data : 8'h00;
   assign o_dq_oe  = w_dq_oe;
   assign o_so     = r_sh[0];
   assign o_io     = r_io_o;
   assign o_io_oe  = r_io_oe;
   assign o_romcen = ~w_rom_sel;
   assign o_ramcen = ~w_ram_sel;
   assign o_raddr  = w_raddr;

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// Directed bench for bandai_mapper_gen2: unlock, boot stream, banking,
// GPIO, relock and reset behaviour with hand-computed expectations.
module tb_bandai_mapper_gen2;

   logic       clk = 1'b0;
   logic       rst, cen, ssn, oen, wen;
   logic [7:0] addr, dq_i, dq_o;
   logic       dq_oe, so, romcen, ramcen;
   logic [3:0] io_i, io_o, io_oe;
   logic [6:0] raddr;
   logic [17:0] pat;
   int         n_pass  = 0;
   int         n_total = 0;
   int         n_fail  = 0;

   bandai_mapper_gen2 dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_cen    (cen),
      .i_ssn    (ssn),
      .i_oen    (oen),
      .i_wen    (wen),
      .i_addr   (addr),
      .i_dq     (dq_i),
      .o_dq     (dq_o),
      .o_dq_oe  (dq_oe),
      .o_so     (so),
      .i_io     (io_i),
      .o_io     (io_o),
      .o_io_oe  (io_oe),
      .o_romcen (romcen),
      .o_ramcen (ramcen),
      .o_raddr  (raddr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic s, input logic c, input logic o, input logic [7:0] a);
      ssn = s; cen = c; oen = o; addr = a;
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      ssn = 1'b0; cen = 1'b0; oen = 1'b1; addr = a; dq_i = d;
      wen = 1'b0;
      tick(4);
      wen = 1'b1;
      tick(4);
      ssn = 1'b1; cen = 1'b1; addr = 8'h00;
      #1;
   endtask

   task automatic unlock();
      addr = 8'h5A; tick(1);
      addr = 8'hA5; tick(1);
      addr = 8'h00; #1;
   endtask

   initial begin
      rst = 1'b1; cen = 1'b1; ssn = 1'b1; oen = 1'b1; wen = 1'b1;
      addr = 8'h00; dq_i = 8'h00; io_i = 4'h0; pat = 18'h05140;
      tick(3);
      chk("rst_so", so, 1'b1);
      chk("rst_romcen", romcen, 1'b1);
      chk("rst_ramcen", ramcen, 1'b1);
      chk("rst_raddr", raddr, 7'h00);
      chk("rst_dq_oe", dq_oe, 1'b0);
      chk("rst_io_oe", io_oe, 4'h0);
      chk("rst_io_o", io_o, 4'h0);
      rst = 1'b0;
      tick(1);

      // Broken key sequence must leave the mapper locked.
      addr = 8'h5A; tick(1);
      addr = 8'h33; tick(1);
      addr = 8'hA5; tick(1);
      for (int n = 2; n < 16; n++) begin
         bus(1'b1, 1'b0, 1'b1, {n[3:0], 4'h0});
         chk($sformatf("locked_romcen_n%0d", n), romcen, 1'b1);
      end
      bus(1'b0, 1'b0, 1'b0, 8'hC0);
      chk("locked_dq_oe", dq_oe, 1'b0);
      chk("locked_dq", dq_o, 8'h00);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      unlock();
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("boot_bit%0d", i), so, pat[i]);
         tick(1);
      end
      chk("boot_tail", so, 1'b1);

      wr(8'hC2, 8'h15);
      bus(1'b1, 1'b0, 1'b0, 8'h25);
      chk("rom0_romcen", romcen, 1'b0);
      chk("rom0_ramcen", ramcen, 1'b1);
      chk("rom0_raddr", raddr, 7'h15);
      chk("rom0_unmapped_dq_oe", dq_oe, 1'b0);
      bus(1'b1, 1'b0, 1'b1, 8'h30);
      chk("rom1_reset_raddr", raddr, 7'h7F);

      wr(8'hC0, 8'h03);
      bus(1'b1, 1'b0, 1'b1, 8'hA7);
      chk("lin_raddr", raddr, 7'h3A);
      chk("lin_romcen", romcen, 1'b0);

      wr(8'hC1, 8'h2B);
      bus(1'b1, 1'b0, 1'b1, 8'h10);
      chk("ram_ramcen", ramcen, 1'b0);
      chk("ram_romcen", romcen, 1'b1);
      chk("ram_raddr", raddr, 7'h2B);

      wr(8'hC3, 8'hC6);
      bus(1'b1, 1'b0, 1'b1, 8'h3F);
      chk("rom1_trunc_raddr", raddr, 7'h46);
      bus(1'b1, 1'b0, 1'b1, 8'h05);
      chk("n0_raddr", raddr, 7'h00);
      chk("n0_romcen", romcen, 1'b1);
      chk("n0_ramcen", ramcen, 1'b1);

      bus(1'b0, 1'b0, 1'b0, 8'hC0);
      chk("rd_lao_oe", dq_oe, 1'b1);
      chk("rd_lao", dq_o, 8'h03);
      bus(1'b0, 1'b0, 1'b0, 8'hC3);
      chk("rd_rom1", dq_o, 8'h46);
      bus(1'b0, 1'b0, 1'b0, 8'hC1);
      chk("rd_ram", dq_o, 8'h2B);
      bus(1'b1, 1'b1, 1'b0, 8'hC1);
      chk("rd_deselected_oe", dq_oe, 1'b0);
      chk("rd_deselected_dq", dq_o, 8'h00);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      // Commit lands on the third clock after the raw strobe rises.
      ssn = 1'b0; cen = 1'b0; addr = 8'hCC; dq_i = 8'h05; wen = 1'b0;
      tick(4);
      wen = 1'b1;
      tick(2);
      chk("io_oe_latency2", io_oe, 4'h0);
      tick(1);
      chk("io_oe_latency3", io_oe, 4'h5);
      tick(1);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      wr(8'hCD, 8'h0F);
      chk("io_o", io_o, 4'hF);
      chk("io_oe", io_oe, 4'h5);
      bus(1'b0, 1'b0, 1'b0, 8'hCD);
      chk("rd_gpio_oe", dq_oe, 1'b1);
      chk("rd_gpio", dq_o, 8'h05);
      io_i = 4'hA;
      tick(1);
      chk("rd_gpio_sync1", dq_o, 8'h05);
      tick(1);
      chk("rd_gpio_sync2", dq_o, 8'h0F);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      wr(8'hCF, 8'h00);
      bus(1'b1, 1'b0, 1'b1, 8'h25);
      chk("relock_bad_data_romcen", romcen, 1'b0);
      bus(1'b1, 1'b1, 1'b1, 8'h00);
      wr(8'hCF, 8'hA5);
      bus(1'b1, 1'b0, 1'b1, 8'h25);
      chk("relock_romcen", romcen, 1'b1);
      chk("relock_raddr", raddr, 7'h00);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      unlock();
      bus(1'b1, 1'b0, 1'b1, 8'h25);
      chk("kept_rom0", raddr, 7'h15);
      chk("kept_io_o", io_o, 4'hF);
      bus(1'b1, 1'b1, 1'b1, 8'h00);

      unlock();
      tick(3);
      chk("stream_mid", so, pat[3]);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_so", so, 1'b1);
      rst = 1'b0;
      bus(1'b1, 1'b0, 1'b1, 8'h25);
      tick(1);
      chk("post_rst_romcen", romcen, 1'b1);
      chk("post_rst_rom0", raddr, 7'h00);
      chk("post_rst_io_oe", io_oe, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
